// File: rtl/reset_seq_pkg.sv
`default_nettype none
// reset_seq_pkg: shared state encoding and timing constants for the
// video-pipeline reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ASSERT   = 3'd1,
      S_HOLD     = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_GAP      = 3'd4,
      S_FAULT    = 3'd5
   } seq_state_t;

   localparam int DEF_CNT_W   = 23;
   localparam int DEF_GAP     = 2097152;
   localparam int DEF_TIMEOUT = 4194303;

   // Short timings so a full sequence fits in a few dozen cycles of simulation.
   localparam int SIM_GAP     = 4;
   localparam int SIM_TIMEOUT = 8;

endpackage
`default_nettype wire

// File: rtl/seq_delay_cnt.sv
`default_nettype none
// seq_delay_cnt: delay counter with synchronous clear and enable; tc flags
// cnt == limit-1 and also freezes the count so it can never wrap.
module seq_delay_cnt
   import reset_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == (limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// reset_sequencer: staggered assert (last stage first) and ack-gated release
// (first stage first) of N_STAGE active-low downstream resets.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_STAGE = 3,
   parameter int GAP     = DEF_GAP,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iREQ,
   input  logic [N_STAGE-1:0] iACK,
   output logic [N_STAGE-1:0] oRST,
   output logic               oBUSY,
   output logic               oDONE,
   output logic               oFAULT,
   output logic [1:0]         oSTAGE
);

   localparam logic [1:0]       LAST    = 2'(N_STAGE - 1);
   localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

   seq_state_t         state, state_nxt;
   logic [1:0]         k, k_nxt;
   logic [N_STAGE-1:0] stage_rst, stage_rst_nxt;
   logic               busy, busy_nxt;
   logic               done, done_nxt;
   logic               fault, fault_nxt;
   logic               cnt_clr, cnt_en, tc;
   logic [CNT_W-1:0]   cnt_limit;

   seq_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (iCLK),
      .rst   (iRST),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (cnt_limit),
      .tc    (tc)
   );

   assign cnt_en = (state != S_IDLE) && (state != S_FAULT);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= S_HOLD;
         k         <= 2'd0;
         stage_rst <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         k         <= k_nxt;
         stage_rst <= stage_rst_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         fault     <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      k_nxt         = k;
      stage_rst_nxt = stage_rst;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      fault_nxt     = fault;
      cnt_clr       = 1'b0;
      cnt_limit     = GAP_LIM;
      case (state)
         S_IDLE: begin
            cnt_clr  = 1'b1;
            busy_nxt = 1'b0;
            if (iREQ) begin
               state_nxt           = S_ASSERT;
               k_nxt               = LAST;
               stage_rst_nxt[LAST] = 1'b0;
               busy_nxt            = 1'b1;
            end
         end
         S_ASSERT: begin
            if (tc) begin
               cnt_clr = 1'b1;
               if (k != 2'd0) begin
                  k_nxt                    = k - 2'd1;
                  stage_rst_nxt[k - 2'd1]  = 1'b0;
               end else begin
                  state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            stage_rst_nxt = '0;
            if (tc) begin
               stage_rst_nxt[0] = 1'b1;
               k_nxt            = 2'd0;
               cnt_clr          = 1'b1;
               state_nxt        = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            cnt_limit = TO_LIM;
            // An ack arriving on the timeout cycle still counts.
            if (iACK[k]) begin
               cnt_clr = 1'b1;
               if (k == LAST) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt = S_GAP;
                  k_nxt     = k + 2'd1;
               end
            end else if (tc) begin
               cnt_clr       = 1'b1;
               state_nxt     = S_FAULT;
               fault_nxt     = 1'b1;
               stage_rst_nxt = '0;
               busy_nxt      = 1'b0;
            end
         end
         S_GAP: begin
            if (tc) begin
               stage_rst_nxt[k] = 1'b1;
               cnt_clr          = 1'b1;
               state_nxt        = S_WAIT_ACK;
            end
         end
         S_FAULT: begin
            cnt_clr       = 1'b1;
            stage_rst_nxt = '0;
            if (iREQ) begin
               fault_nxt = 1'b0;
               busy_nxt  = 1'b1;
               k_nxt     = LAST;
               state_nxt = S_ASSERT;
            end
         end
         default: begin
            cnt_clr       = 1'b1;
            stage_rst_nxt = '0;
            state_nxt     = S_HOLD;
         end
      endcase
   end

   assign oRST   = stage_rst;
   assign oBUSY  = busy;
   assign oDONE  = done;
   assign oFAULT = fault;
   assign oSTAGE = k;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// tb_reset_sequencer: directed stimulus; every change of the output vector is
// matched against a queue of expected (edge, value) events.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   typedef struct {
      int         at;
      logic [7:0] vec;
      string      tag;
   } exp_t;

   logic       clk;
   logic       iRST;
   logic       iREQ;
   logic [2:0] iACK;
   logic [2:0] oRST;
   logic       oBUSY;
   logic       oDONE;
   logic       oFAULT;
   logic [1:0] oSTAGE;

   exp_t       exp_q[$];
   int         edge_no = 0;
   int         n_cmp   = 0;
   int         n_bad   = 0;
   logic [7:0] prev    = 8'bx;
   logic [7:0] cur;
   exp_t       e;

   reset_sequencer #(
      .N_STAGE (3),
      .GAP     (SIM_GAP),
      .TIMEOUT (SIM_TIMEOUT),
      .CNT_W   (DEF_CNT_W)
   ) dut (
      .iCLK   (clk),
      .iRST   (iRST),
      .iREQ   (iREQ),
      .iACK   (iACK),
      .oRST   (oRST),
      .oBUSY  (oBUSY),
      .oDONE  (oDONE),
      .oFAULT (oFAULT),
      .oSTAGE (oSTAGE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_no <= edge_no + 1;

   // {oRST, oBUSY, oDONE, oFAULT, oSTAGE}
   function automatic logic [7:0] ov(input logic [2:0] r, input logic b,
                                     input logic d, input logic f,
                                     input logic [1:0] s);
      return {r, b, d, f, s};
   endfunction

   task automatic push(input int at, input logic [7:0] v, input string tag);
      exp_t x;
      x.at  = at;
      x.vec = v;
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   // Top-down assertion after a request accepted on edge b+1.
   task automatic push_assert(input int b);
      push(b + 1, ov(3'b011, 1, 0, 0, 2'd2), "assert_s2");
      push(b + 5, ov(3'b001, 1, 0, 0, 2'd1), "assert_s1");
      push(b + 9, ov(3'b000, 1, 0, 0, 2'd0), "assert_s0");
   endtask

   // Bottom-up release: stage 0 released on edge b0, its ack taken d cycles late.
   task automatic push_release(input int b0, input int d);
      int c;
      c = b0 + d;
      push(b0,     ov(3'b001, 1, 0, 0, 2'd0), "release_s0");
      push(c + 1,  ov(3'b001, 1, 0, 0, 2'd1), "ack_s0");
      push(c + 5,  ov(3'b011, 1, 0, 0, 2'd1), "release_s1");
      push(c + 6,  ov(3'b011, 1, 0, 0, 2'd2), "ack_s1");
      push(c + 10, ov(3'b111, 1, 0, 0, 2'd2), "release_s2");
      push(c + 11, ov(3'b111, 0, 1, 0, 2'd2), "done_pulse");
      push(c + 12, ov(3'b111, 0, 0, 0, 2'd2), "done_low");
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int n);
      while (edge_no < n) tick();
   endtask

   always @(negedge clk) begin
      cur = {oRST, oBUSY, oDONE, oFAULT, oSTAGE};
      if (cur !== prev) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: edge %0d got %b, required no change", edge_no, cur);
         end else begin
            e = exp_q.pop_front();
            if (e.vec !== cur || (e.at >= 0 && e.at != edge_no)) begin
               n_bad++;
               $display("FAIL %s: edge %0d got %b, required %b at edge %0d",
                        e.tag, edge_no, cur, e.vec, e.at);
            end
         end
         prev = cur;
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      iRST = 1'b1;
      iREQ = 1'b0;
      iACK = 3'b111;
      push(-1, ov(3'b000, 1, 0, 0, 2'd0), "reset_state");

      // Power-on release with all acks high.
      repeat (5) tick();
      iRST = 1'b0;
      b = edge_no;
      push_release(b + 4, 0);
      wait_edge(b + 20);

      // Request from IDLE: full top-down assert, hold, bottom-up release.
      b = edge_no;
      iREQ = 1'b1;
      push_assert(b);
      push_release(b + 17, 0);
      tick();
      iREQ = 1'b0;
      wait_edge(b + 32);

      // Stage 1 never acks during power-on: timeout fault, then recovery.
      b = edge_no;
      iRST = 1'b1;
      iACK = 3'b101;
      push(b, ov(3'b000, 1, 0, 0, 2'd0), "t3_async_reset");
      tick();
      tick();
      iRST = 1'b0;
      b = edge_no;
      push(b + 4,  ov(3'b001, 1, 0, 0, 2'd0), "t3_release_s0");
      push(b + 5,  ov(3'b001, 1, 0, 0, 2'd1), "t3_ack_s0");
      push(b + 9,  ov(3'b011, 1, 0, 0, 2'd1), "t3_release_s1");
      push(b + 17, ov(3'b000, 0, 0, 1, 2'd1), "t3_timeout_fault");
      wait_edge(b + 20);
      b = edge_no;
      iACK = 3'b111;
      iREQ = 1'b1;
      push(b + 1, ov(3'b000, 1, 0, 0, 2'd2), "t3_fault_cleared");
      push(b + 5, ov(3'b000, 1, 0, 0, 2'd1), "t3_assert_s1");
      push(b + 9, ov(3'b000, 1, 0, 0, 2'd0), "t3_assert_s0");
      push_release(b + 17, 0);
      tick();
      iREQ = 1'b0;
      wait_edge(b + 32);

      // Ack for stage 0 lands exactly on the last timeout cycle, then drops.
      b = edge_no;
      iREQ = 1'b1;
      iACK = 3'b110;
      push_assert(b);
      push_release(b + 17, 7);
      tick();
      iREQ = 1'b0;
      wait_edge(b + 24);
      iACK = 3'b111;
      tick();
      iACK = 3'b110;
      wait_edge(b + 40);
      iACK = 3'b111;

      // Requests during HOLD and WAIT_ACK are ignored.
      b = edge_no;
      iREQ = 1'b1;
      push_assert(b);
      push_release(b + 17, 0);
      tick();
      iREQ = 1'b0;
      wait_edge(b + 14);
      iREQ = 1'b1;
      tick();
      iREQ = 1'b0;
      wait_edge(b + 22);
      iREQ = 1'b1;
      tick();
      iREQ = 1'b0;
      wait_edge(b + 32);

      // Asynchronous reset while stage 2 is in its GAP.
      b = edge_no;
      iREQ = 1'b1;
      push_assert(b);
      push(b + 17, ov(3'b001, 1, 0, 0, 2'd0), "t5_release_s0");
      push(b + 18, ov(3'b001, 1, 0, 0, 2'd1), "t5_ack_s0");
      push(b + 22, ov(3'b011, 1, 0, 0, 2'd1), "t5_release_s1");
      push(b + 23, ov(3'b011, 1, 0, 0, 2'd2), "t5_ack_s1");
      tick();
      iREQ = 1'b0;
      wait_edge(b + 24);
      iRST = 1'b1;
      push(b + 24, ov(3'b000, 1, 0, 0, 2'd0), "t5_mid_reset");
      tick();
      tick();
      iRST = 1'b0;
      b = edge_no;
      push_release(b + 4, 0);
      wait_edge(b + 20);

      // Stray ack on a stage still in reset; stage 0 never acks.
      b = edge_no;
      iREQ = 1'b1;
      iACK = 3'b100;
      push_assert(b);
      push(b + 17, ov(3'b001, 1, 0, 0, 2'd0), "t6_release_s0");
      push(b + 25, ov(3'b000, 0, 0, 1, 2'd0), "t6_timeout_s0");
      tick();
      iREQ = 1'b0;
      wait_edge(b + 32);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("FAIL %s: never observed, required %b at edge %0d", e.tag, e.vec, e.at);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
